// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch PC control block.
package if_pkg;

  localparam int unsigned PC_WIDTH_DEF = 10;
  localparam int unsigned RESET_PC_DEF = 0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } if_state_t;

endpackage

// File: rtl/if_pc_ctrl_if.sv
// Fetch-stage bundle between the IF top level and the PC controller.
interface if_pc_ctrl_if
  import if_pkg::*;
#(
  parameter int unsigned PC_WIDTH = PC_WIDTH_DEF
) ();

  logic [PC_WIDTH-1:0] pc_plus;
  logic                stall;
  logic                branch_taken;
  logic [PC_WIDTH-1:0] branch_target;
  logic                jump;
  logic [PC_WIDTH-1:0] jump_target;
  logic                halt;

  logic [PC_WIDTH-1:0] pc_out;
  logic                imem_en;
  logic [PC_WIDTH-1:0] ifid_pc_next;
  logic                ifid_valid;
  logic                halted;

  modport master (
    output pc_plus, stall, branch_taken, branch_target, jump, jump_target, halt,
    input  pc_out, imem_en, ifid_pc_next, ifid_valid, halted
  );

  modport slave (
    input  pc_plus, stall, branch_taken, branch_target, jump, jump_target, halt,
    output pc_out, imem_en, ifid_pc_next, ifid_valid, halted
  );

endinterface

// File: rtl/pc_next_mux.sv
// Next-PC select: a taken branch beats a jump, and either beats the sequential PC+1.
module pc_next_mux #(
  parameter int unsigned PC_WIDTH = 10
) (
  input  logic [PC_WIDTH-1:0] pc_plus_i,
  input  logic                branch_taken_i,
  input  logic [PC_WIDTH-1:0] branch_target_i,
  input  logic                jump_i,
  input  logic [PC_WIDTH-1:0] jump_target_i,
  output logic [PC_WIDTH-1:0] next_pc_o,
  output logic                redirect_o
);

  always_comb begin
    redirect_o = branch_taken_i | jump_i;
    next_pc_o  = pc_plus_i;
    if (branch_taken_i) begin
      next_pc_o = branch_target_i;
    end else if (jump_i) begin
      next_pc_o = jump_target_i;
    end
  end

endmodule

// File: rtl/if_pc_ctrl.sv
// Program counter and fetch control: sequential/redirect/stall/halt sequencing
// plus the IF/ID next-PC and valid sideband aligned with the synchronous imem.
module if_pc_ctrl
  import if_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  if_pc_ctrl_if.slave   bus
);

  if_state_t           state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] ifid_pc_next_q, ifid_pc_next_d;
  logic                ifid_valid_q, ifid_valid_d;
  logic                imem_en_c;
  logic                halted_c;
  logic [PC_WIDTH-1:0] mux_next_pc;
  logic                redirect;

  pc_next_mux #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_next_mux (
    .pc_plus_i       (bus.pc_plus),
    .branch_taken_i  (bus.branch_taken),
    .branch_target_i (bus.branch_target),
    .jump_i          (bus.jump),
    .jump_target_i   (bus.jump_target),
    .next_pc_o       (mux_next_pc),
    .redirect_o      (redirect)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC;
      ifid_pc_next_q <= '0;
      ifid_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ifid_pc_next_q <= ifid_pc_next_d;
      ifid_valid_q   <= ifid_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (bus.halt && !redirect) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // A redirect squashes the wrong-path fetch and overrides both halt and stall.
  always_comb begin
    pc_d           = pc_q;
    ifid_pc_next_d = ifid_pc_next_q;
    ifid_valid_d   = ifid_valid_q;
    imem_en_c      = 1'b0;
    halted_c       = 1'b0;
    case (state_q)
      ST_RUN: begin
        imem_en_c = !bus.stall || redirect;
        if (redirect) begin
          pc_d           = mux_next_pc;
          ifid_pc_next_d = bus.pc_plus;
          ifid_valid_d   = 1'b0;
        end else if (bus.halt) begin
          ifid_valid_d   = 1'b0;
        end else if (!bus.stall) begin
          pc_d           = mux_next_pc;
          ifid_pc_next_d = bus.pc_plus;
          ifid_valid_d   = 1'b1;
        end
      end
      ST_HALTED: begin
        halted_c = 1'b1;
      end
      default: begin
        halted_c = 1'b0;
      end
    endcase
  end

  assign bus.pc_out       = pc_q;
  assign bus.imem_en      = imem_en_c;
  assign bus.ifid_pc_next = ifid_pc_next_q;
  assign bus.ifid_valid   = ifid_valid_q;
  assign bus.halted       = halted_c;

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Directed bench for if_pc_ctrl with a behavioural PC+1 fetch adder alongside.
module tb_if_pc_ctrl;
  import if_pkg::*;

  localparam int unsigned W = 10;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  if_pc_ctrl_if #(.PC_WIDTH(W)) bus ();

  if_pc_ctrl #(
    .PC_WIDTH (W),
    .RESET_PC (10'd0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External fetch adder: in_a = pc_out, in_b tied to 1, wraps at 2^W.
  assign bus.pc_plus = bus.pc_out + 10'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.jump          = 1'b0;
    bus.jump_target   = '0;
    bus.halt          = 1'b0;
  endtask

  task automatic chk_seq(input string tag, input int pc, input int pcn, input int vld);
    check_eq({tag, ".pc"}, 32'(bus.pc_out), pc);
    check_eq({tag, ".pcn"}, 32'(bus.ifid_pc_next), pcn);
    check_eq({tag, ".vld"}, 32'(bus.ifid_valid), vld);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle_inputs();

    // Reset held two cycles
    step();
    step();
    chk_seq("rst", 0, 0, 0);
    check_eq("rst.halted", 32'(bus.halted), 0);
    reset = 1'b0;
    check_eq("rst.imem_en", 32'(bus.imem_en), 1);

    // Free-running sequential fetch
    step(); chk_seq("seq1", 1, 1, 1);
    step(); chk_seq("seq2", 2, 2, 1);
    step(); chk_seq("seq3", 3, 3, 1);
    step(); chk_seq("seq4", 4, 4, 1);
    step(); chk_seq("seq5", 5, 5, 1);

    // Stall for three cycles at PC 5
    bus.stall = 1'b1;
    #1;
    check_eq("stall.imem_en", 32'(bus.imem_en), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_seq("stall", 5, 5, 1);
      check_eq("stall.imem_en_h", 32'(bus.imem_en), 0);
    end
    bus.stall = 1'b0;
    step(); chk_seq("unstall", 6, 6, 1);
    step(); step(); chk_seq("seq8", 8, 8, 1);

    // Branch and jump together: branch wins
    bus.branch_taken  = 1'b1;
    bus.branch_target = 10'd40;
    bus.jump          = 1'b1;
    bus.jump_target   = 10'd99;
    step();
    idle_inputs();
    chk_seq("br", 40, 9, 0);
    step(); chk_seq("br_seq", 41, 41, 1);

    // Jump while stalled is honoured
    bus.stall       = 1'b1;
    bus.jump        = 1'b1;
    bus.jump_target = 10'd200;
    #1;
    check_eq("jstall.imem_en", 32'(bus.imem_en), 1);
    step();
    idle_inputs();
    check_eq("jstall.pc", 32'(bus.pc_out), 200);
    check_eq("jstall.vld", 32'(bus.ifid_valid), 0);
    step(); chk_seq("jstall_seq", 201, 201, 1);

    // Halt alongside a redirect is ignored
    bus.halt          = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 10'd300;
    step();
    idle_inputs();
    check_eq("haltredir.pc", 32'(bus.pc_out), 300);
    check_eq("haltredir.halted", 32'(bus.halted), 0);

    // Wrap from 1023 to 0
    bus.jump        = 1'b1;
    bus.jump_target = 10'd1023;
    step();
    idle_inputs();
    check_eq("wrap.pre", 32'(bus.pc_out), 1023);
    step(); chk_seq("wrap", 0, 0, 1);
    check_eq("wrap.halted", 32'(bus.halted), 0);

    // Halt at PC 12
    bus.jump        = 1'b1;
    bus.jump_target = 10'd12;
    step();
    idle_inputs();
    check_eq("pre_halt.pc", 32'(bus.pc_out), 12);
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    check_eq("halt.pc", 32'(bus.pc_out), 12);
    check_eq("halt.vld", 32'(bus.ifid_valid), 0);
    check_eq("halt.halted", 32'(bus.halted), 1);
    check_eq("halt.imem_en", 32'(bus.imem_en), 0);

    // Inputs other than reset are ignored while halted
    bus.branch_taken  = 1'b1;
    bus.branch_target = 10'd500;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("halted.pc", 32'(bus.pc_out), 12);
      check_eq("halted.flag", 32'(bus.halted), 1);
      check_eq("halted.imem_en", 32'(bus.imem_en), 0);
      check_eq("halted.vld", 32'(bus.ifid_valid), 0);
    end
    idle_inputs();

    // Reset recovers fetch
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_seq("rerst", 0, 0, 0);
    check_eq("rerst.halted", 32'(bus.halted), 0);
    check_eq("rerst.imem_en", 32'(bus.imem_en), 1);
    step(); chk_seq("resume", 1, 1, 1);

    // Reset during a stalled redirect leaves no residue
    bus.stall       = 1'b1;
    bus.jump        = 1'b1;
    bus.jump_target = 10'd77;
    reset           = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    chk_seq("rst_mid", 0, 0, 0);
    step(); chk_seq("rst_mid_seq", 1, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
